// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO arbiter slice.
//   DW, DEPTH, CW : data width, stack capacity, occupancy counter width
//   OP_PUSH/OP_POP: encoding of the client rw bit
//   state_e       : arbiter sequencer states
package lifo_pkg;
  localparam int DW    = 4;
  localparam int DEPTH = 5;
  localparam int CW    = 3;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP,
    S_FLUSH
  } state_e;
endpackage

// File: rtl/lifo_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (combinational).
//   req   : request vector {client1, client0}
//   last  : client served most recently (0 or 1)
//   grant : one-hot grant, zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: favour whichever client was not served last.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between two clients with round-robin arbitration.
// Each op is a single LIFO access; pops add a capture cycle for the
// registered LIFO output. Tracks occupancy and supports a deferred flush.
//   clk, rst                 : clock, synchronous active-high reset
//   req*/rw*/wdata*          : client requests (rw 0=push, 1=pop)
//   flush / flush_done       : stack clear request / completion pulse
//   gnt, done, err, rdata    : grant and response to the granted client
//   count                    : current occupancy 0..DEPTH
//   lifo_*                   : control to / status from the LIFO instance
module lifo_arbiter #(
  parameter int DW    = lifo_pkg::DW,
  parameter int DEPTH = lifo_pkg::DEPTH,
  parameter int CW    = lifo_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          flush,
  output logic [1:0]    gnt,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          flush_done,
  output logic [CW-1:0] count,
  output logic [DW-1:0] lifo_data,
  output logic          lifo_rw,
  output logic          lifo_en,
  output logic          lifo_rst,
  input  logic [DW-1:0] lifo_out,
  input  logic          lifo_empty,
  input  logic          lifo_full
);
  import lifo_pkg::*;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          flush_done_q, flush_done_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;
  logic          flush_pend_q, flush_pend_d;
  logic          op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    arb_gnt;
  logic          reject;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .last  (last_q),
    .grant (arb_gnt)
  );

  // Count guard keeps occupancy bounded even if the full flag lags.
  assign reject = (op_q == OP_PUSH) ? (lifo_full || (count_q == CW'(DEPTH)))
                                    : lifo_empty;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = 1'b0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    flush_done_d = 1'b0;
    count_d      = count_q;
    last_d       = last_q;
    flush_pend_d = flush_pend_q;
    op_d         = op_q;
    data_d       = data_q;
    lifo_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d = S_FLUSH;
        end else if (req0 || req1) begin
          gnt_d   = arb_gnt;
          op_d    = arb_gnt[1] ? rw1 : rw0;
          data_d  = arb_gnt[1] ? wdata1 : wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) flush_pend_d = 1'b1;
        if (reject) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          lifo_en = 1'b1;
          if (op_q == OP_PUSH) begin
            count_d = count_q + 1'b1;
            done_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            count_d = count_q - 1'b1;
            state_d = S_CAPT;
          end
        end
      end
      S_CAPT: begin
        if (flush) flush_pend_d = 1'b1;
        rdata_d = lifo_out;
        done_d  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (flush) flush_pend_d = 1'b1;
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        count_d      = '0;
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
      count_q      <= '0;
      last_q       <= 1'b1;
      flush_pend_q <= 1'b0;
      op_q         <= OP_PUSH;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      flush_done_q <= flush_done_d;
      count_q      <= count_d;
      last_q       <= last_d;
      flush_pend_q <= flush_pend_d;
      op_q         <= op_d;
      data_q       <= data_d;
    end
  end

  // Stack is cleared on arbiter reset as well as by a flush.
  assign lifo_rst   = rst || (state_q == S_FLUSH);
  assign lifo_rw    = op_q;
  assign lifo_data  = data_q;
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;
endmodule

// File: tb/tb_lifo_arbiter.sv
module tb_lifo_arbiter;
  localparam int DW = 4, DEPTH = 5, CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 0, req1 = 0, rw0 = 0, rw1 = 0, flush = 0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    gnt;
  logic          done, err, flush_done, lifo_rw, lifo_en, lifo_rst;
  logic [DW-1:0] rdata, lifo_data;
  logic [DW-1:0] lifo_out = '0;
  logic [CW-1:0] count;
  logic          lifo_empty, lifo_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lifo_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .wdata0(wdata0), .wdata1(wdata1), .flush(flush), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .flush_done(flush_done), .count(count),
    .lifo_data(lifo_data), .lifo_rw(lifo_rw), .lifo_en(lifo_en),
    .lifo_rst(lifo_rst), .lifo_out(lifo_out), .lifo_empty(lifo_empty),
    .lifo_full(lifo_full)
  );

  // Behavioural LIFO instance (environment, registered output).
  logic [DW-1:0] mem [DEPTH];
  int            sp = 0;
  assign lifo_empty = (sp == 0);
  assign lifo_full  = (sp == DEPTH);
  always @(posedge clk) begin
    if (lifo_rst) sp <= 0;
    else if (lifo_en) begin
      if (!lifo_rw) begin
        if (sp < DEPTH) begin mem[sp] <= lifo_data; sp <= sp + 1; end
      end else if (sp > 0) begin
        lifo_out <= mem[sp-1]; sp <= sp - 1;
      end
    end
  end

  // Monitor of LIFO accesses.
  int            en_cnt = 0;
  logic          en_rw = 0;
  logic [DW-1:0] en_data = '0;
  always @(posedge clk) if (lifo_en) begin
    en_cnt  <= en_cnt + 1;
    en_rw   <= lifo_rw;
    en_data <= lifo_data;
  end

  // Reference model: stack contents and last popped value.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    last_rd = '0;
  endtask

  // One client transaction, started at a negedge with the DUT idle.
  task automatic do_op(input int c, input logic rw, input logic [DW-1:0] d);
    int n, base, exp_lat;
    bit seen, exp_err;
    logic [DW-1:0] exp_rd;
    exp_err = rw ? (stk.size() == 0) : (stk.size() == DEPTH);
    exp_rd  = last_rd;
    if (!exp_err) begin
      if (rw) exp_rd = stk.pop_back();
      else    stk.push_back(d);
    end
    exp_lat = (rw && !exp_err) ? 4 : 3;
    base = en_cnt;
    if (c == 0) begin req0 = 1; rw0 = rw; wdata0 = d; end
    else        begin req1 = 1; rw1 = rw; wdata1 = d; end
    n = 1; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("latency", n, exp_lat);
    chk("err", err, exp_err);
    chk("gnt", gnt, (c == 0) ? 2'b01 : 2'b10);
    chk("count", count, stk.size());
    chk("en_pulses", en_cnt - base, exp_err ? 0 : 1);
    if (!exp_err) chk("lifo_rw", en_rw, rw);
    if (!exp_err && !rw) chk("lifo_data", en_data, d);
    if (rw && !exp_err) begin
      chk("rdata", rdata, exp_rd);
      last_rd = exp_rd;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("err_clr", err, 0);
    chk("gnt_clr", gnt, 0);
    chk("rdata_hold", rdata, last_rd);
  endtask

  task automatic flush_idle();
    flush = 1;
    @(negedge clk);
    chk("flush_rst", lifo_rst, 1);
    flush = 0;
    @(negedge clk);
    chk("flush_done", flush_done, 1);
    chk("flush_count", count, 0);
    stk.delete();
    @(negedge clk);
    chk("flush_done_clr", flush_done, 0);
    chk("flush_once", lifo_rst, 0);
  endtask

  initial begin
    int k, cyc;
    logic [DW-1:0] exp_rd;

    // Reset values while rst is held.
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_count", count, 0);
    chk("rst_lifo_rst", lifo_rst, 1);
    chk("rst_lifo_en", lifo_en, 0);
    rst = 0;

    // Pushes from client 0, then pops from client 1 in reverse order.
    do_op(0, 0, 4'hA);
    do_op(0, 0, 4'h5);
    do_op(0, 0, 4'hC);
    do_op(1, 1, 4'h0);
    chk("pop1", rdata, 4'hC);
    do_op(1, 1, 4'h0);
    chk("pop2", rdata, 4'h5);
    do_op(1, 1, 4'h0);
    chk("pop3", rdata, 4'hA);

    // Underflow, fill, overflow.
    do_op(0, 1, 4'h0);
    for (int i = 0; i < DEPTH; i++) do_op(i % 2, 0, 4'(i + 1));
    do_op(1, 0, 4'hF);
    chk("full_count", count, DEPTH);

    // Both clients pushing continuously: grants alternate starting at 0.
    do_reset();
    req0 = 1; req1 = 1; rw0 = 0; rw1 = 0; wdata0 = 4'h1; wdata1 = 4'h2;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done) begin
        chk("rr_gnt", gnt, (k % 2) ? 2'b10 : 2'b01);
        stk.push_back((k % 2) ? 4'h2 : 4'h1);
        k++;
        if (k == 4) begin req0 = 0; req1 = 0; end
      end
    end
    chk("rr_grants", k, 4);
    @(negedge clk);
    chk("rr_count", count, 4);
    do_op(0, 1, 4'h0);
    chk("rr_pop", rdata, 4'h2);

    // Flush raised during a pop's capture cycle.
    do_reset();
    do_op(0, 0, 4'h3);
    do_op(0, 0, 4'h6);
    do_op(0, 0, 4'h9);
    exp_rd = stk.pop_back();
    req1 = 1; rw1 = 1;
    @(negedge clk);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fc_done", done, 1);
    chk("fc_err", err, 0);
    chk("fc_rdata", rdata, exp_rd);
    chk("fc_count", count, 2);
    req1 = 0;
    last_rd = exp_rd;
    @(negedge clk);
    chk("fc_no_rst_yet", lifo_rst, 0);
    @(negedge clk);
    chk("fc_lifo_rst", lifo_rst, 1);
    @(negedge clk);
    chk("fc_flush_done", flush_done, 1);
    chk("fc_count0", count, 0);
    chk("fc_rst_clr", lifo_rst, 0);
    stk.delete();

    // Reset mid-ISSUE.
    do_op(1, 0, 4'h4);
    req0 = 1; rw0 = 0; wdata0 = 4'h7;
    @(negedge clk);
    rst = 1;
    #1 chk("mi_lifo_rst", lifo_rst, 1);
    @(negedge clk);
    chk("mi_gnt", gnt, 0);
    chk("mi_done", done, 0);
    chk("mi_count", count, 0);
    chk("mi_lifo_rst_hold", lifo_rst, 1);
    rst = 0; req0 = 0;
    stk.delete();
    last_rd = '0;
    @(negedge clk);
    chk("mi_rst_rel", lifo_rst, 0);

    // Random single-client traffic with occasional idle flushes.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) flush_idle();
      else do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one 4-bit LIFO stack between two requesters (client 0, client 1), using round-robin arbitration.
- Sequences each push/pop as a single one-cycle LIFO access, captures pop data, and returns a done/err response to the granted client.
- Tracks stack occupancy and provides a flush that clears the stack without a global reset.
- Sits between the client logic and the LIFO instance; it is the only driver of the LIFO control inputs.

Parameters:
- DW, 4, data width; matches the LIFO data port.
- DEPTH, 5, LIFO capacity in entries; used for the occupancy counter range.
- CW, 3, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  request from client 0 / client 1.
- rw0, rw1  in  1 each  operation: 0=push, 1=pop (LIFO convention).
- wdata0, wdata1  in  DW each  push data.
- flush  in  1  request to clear the stack.
- gnt  out  2  one-hot grant, held from ISSUE through RESP.
- done  out  1  one-cycle completion pulse to the granted client.
- err  out  1  valid with done; 1 = op rejected (push on full, pop on empty).
- rdata  out  DW  pop result; valid with done when the op was a pop and err=0.
- flush_done  out  1  one-cycle pulse after a flush completes.
- count  out  CW  current stack occupancy, 0..DEPTH.
- lifo_data  out  DW  to LIFO data.
- lifo_rw  out  1  to LIFO rw.
- lifo_en  out  1  to LIFO en.
- lifo_rst  out  1  to LIFO rst.
- lifo_out  in  DW  from LIFO out (registered inside the LIFO).
- lifo_empty, lifo_full  in  1 each  LIFO status flags.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, gnt=0, done=0, err=0, rdata=0, flush_done=0, count=0, last-served pointer=1 (so client 0 wins the first tie), flush_pend=0.
- lifo_rst = rst OR (state==FLUSH). The stack is therefore cleared whenever the arbiter resets, including mid-operation.
- lifo_en is 1 only in ISSUE, and only for an accepted op. lifo_rw and lifo_data are driven from registered op/data at all times.
- States: IDLE, ISSUE, CAPT, RESP, FLUSH.
- IDLE:
  - If flush or flush_pend is set -> FLUSH; flush has priority over requests.
  - Else, if any req is high: arbitrate, latch the winner's rw/wdata, set gnt -> ISSUE.
  - Round robin: with one req, grant it; with both, grant the client not served last.
- ISSUE:
  - Check the LIFO flags this cycle.
  - Push with lifo_full=1, or pop with lifo_empty=1 -> reject: no lifo_en, set err=1 -> RESP.
  - Otherwise assert lifo_en for one cycle. Push: count+1 -> RESP. Pop: count-1 -> CAPT.
- CAPT: rdata <= lifo_out -> RESP.
- RESP:
  - done=1 and err valid for exactly one cycle; update the last-served pointer.
  - Next cycle: gnt=0, err=0 -> IDLE.
- FLUSH: lifo_rst=1 for one cycle, count<=0, flush_pend<=0, flush_done=1 the next cycle -> IDLE.
- Flush during ISSUE/CAPT/RESP: sets sticky flush_pend. The in-flight op completes first; the flush runs from the following IDLE.
- Latency (req seen high in IDLE -> done):
  - push: 3 cycles (IDLE, ISSUE, RESP);
  - pop: 4 cycles (adds CAPT);
  - reject: 3 cycles.
- Client handshake:
  - Hold req, rw and wdata stable until done.
  - Deassert req on the edge where done=1; otherwise a new request is taken in the next IDLE.
- Back-to-back: with both reqs held continuously, grants alternate 0,1,0,1.
- Count saturation: count never exceeds DEPTH or goes below 0, since rejected ops do not change it.
- rdata holds its last value outside done.

Decomposition:
- Shared package (lifo_pkg):
  - constants DW, DEPTH, CW;
  - OP_PUSH=0, OP_POP=1;
  - state encoding enum (IDLE, ISSUE, CAPT, RESP, FLUSH).
- One sub-module: rr_arb2, a 2-way round-robin arbiter (inputs req[1:0], last; outputs one-hot grant). The main FSM and counter stay in lifo_arbiter.
- The LIFO itself is instantiated at the integration level, not inside this block.

Test Plan:
- Reset, then client 0 pushes 4'hA -> lifo_en pulses one cycle with lifo_rw=0, lifo_data=A; done at cycle 3 with err=0; count=1.
- Pushes A, 5, C from client 0, then 3 pops from client 1 -> rdata C, 5, A in order, each done 4 cycles after the req is seen; count returns to 0.
- Both clients continuously request pushes after reset -> gnt sequence 01,10,01,10 (client 0 first).
- Pop on empty stack -> done with err=1, lifo_en never asserted, count stays 0. Push 5 times, then a 6th push -> err=1, count=5.
- Flush asserted during a pop's CAPT cycle (count=3 before the pop) -> the pop completes with valid rdata and count=2; lifo_rst then pulses for one cycle; flush_done asserts; count=0.
- rst asserted mid-ISSUE -> next cycle state=IDLE, gnt=0, done=0, count=0, lifo_rst=1 while rst is high.
